// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants init, auto-refresh, write and read sub-blocks one at a
// time, muxes the granted block onto the SDRAM pins and recovers stuck operations.
module sdram_arbit #(
   parameter logic [7:0] TIMEOUT = 8'd255,
   parameter logic [3:0] NOP     = 4'b0111
) (
   input  logic        sclk,
   input  logic        s_rst_n,
   input  logic        flag_init_end,
   input  logic [3:0]  init_cmd,
   input  logic [11:0] init_addr,
   input  logic        ref_req,
   input  logic        flag_ref_end,
   input  logic [3:0]  aref_cmd,
   input  logic [11:0] aref_addr,
   input  logic        wr_req,
   input  logic        flag_wr_end,
   input  logic [3:0]  wr_cmd,
   input  logic [11:0] wr_addr,
   input  logic [1:0]  wr_bank,
   input  logic        rd_req,
   input  logic        flag_rd_end,
   input  logic [3:0]  rd_cmd,
   input  logic [11:0] rd_addr,
   input  logic [1:0]  rd_bank,
   output logic [4:0]  state,
   output logic        ref_en,
   output logic        wr_en,
   output logic        rd_en,
   output logic [3:0]  sdram_cmd,
   output logic [11:0] sdram_addr,
   output logic [1:0]  sdram_bank,
   output logic        sdram_cke,
   output logic        timeout_err
);

   // One-hot encodings are decoded directly by the downstream sub-blocks.
   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      ARBIT = 5'b00010,
      AREF  = 5'b00100,
      READ  = 5'b01000,
      WRITE = 5'b10000
   } state_t;

   state_t      cur;
   state_t      nxt;
   logic [7:0]  op_cnt;
   logic [7:0]  op_cnt_nxt;
   logic        ref_en_nxt;
   logic        wr_en_nxt;
   logic        rd_en_nxt;
   logic        timeout_nxt;
   logic        end_flag;
   logic        expired;

   assign state    = cur;
   assign expired  = (op_cnt == TIMEOUT);
   assign end_flag = ((cur == AREF)  && flag_ref_end) ||
                     ((cur == WRITE) && flag_wr_end)  ||
                     ((cur == READ)  && flag_rd_end);

   always_comb begin
      nxt         = cur;
      op_cnt_nxt  = '0;
      ref_en_nxt  = 1'b0;
      wr_en_nxt   = 1'b0;
      rd_en_nxt   = 1'b0;
      timeout_nxt = 1'b0;
      case (cur)
         IDLE: begin
            if (flag_init_end) nxt = ARBIT;
         end
         ARBIT: begin
            if (ref_req) begin
               nxt        = AREF;
               ref_en_nxt = 1'b1;
            end else if (wr_req) begin
               nxt       = WRITE;
               wr_en_nxt = 1'b1;
            end else if (rd_req) begin
               nxt       = READ;
               rd_en_nxt = 1'b1;
            end
         end
         AREF, WRITE, READ: begin
            // A completion flag arriving on the expiry cycle takes precedence over the watchdog.
            if (end_flag) begin
               nxt = ARBIT;
            end else if (expired) begin
               nxt         = ARBIT;
               timeout_nxt = 1'b1;
            end else begin
               op_cnt_nxt = (op_cnt == '1) ? op_cnt : op_cnt + 8'd1;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         cur         <= IDLE;
         op_cnt      <= '0;
         ref_en      <= 1'b0;
         wr_en       <= 1'b0;
         rd_en       <= 1'b0;
         timeout_err <= 1'b0;
         sdram_cke   <= 1'b0;
      end else begin
         cur         <= nxt;
         op_cnt      <= op_cnt_nxt;
         ref_en      <= ref_en_nxt;
         wr_en       <= wr_en_nxt;
         rd_en       <= rd_en_nxt;
         timeout_err <= timeout_nxt;
         sdram_cke   <= 1'b1;
      end
   end

   always_comb begin
      sdram_cmd  = NOP;
      sdram_addr = '0;
      sdram_bank = '0;
      case (cur)
         IDLE: begin
            sdram_cmd  = init_cmd;
            sdram_addr = init_addr;
         end
         AREF: begin
            sdram_cmd  = aref_cmd;
            sdram_addr = aref_addr;
         end
         WRITE: begin
            sdram_cmd  = wr_cmd;
            sdram_addr = wr_addr;
            sdram_bank = wr_bank;
         end
         READ: begin
            sdram_cmd  = rd_cmd;
            sdram_addr = rd_addr;
            sdram_bank = rd_bank;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Top-level SDRAM arbiter: the stage directly upstream of the read, write, auto-refresh and init sub-blocks. It owns the 5-bit `state` bus that those sub-blocks decode. It grants one requester at a time and multiplexes that requester's command, address and bank onto the SDRAM pins. A per-operation watchdog recovers the FSM if a sub-block never reports completion.

## Interface
Parameters:
- `TIMEOUT`, default 8'd255: maximum cycles spent in AREF/WRITE/READ before forced return to ARBIT.
- `NOP`, default 4'b0111: `{cs_n,ras_n,cas_n,we_n}` idle command.

Ports:
- `sclk`  in  1  system clock; all state on rising edge.
- `s_rst_n`  in  1  reset, asynchronous, active-low.
- `flag_init_end`  in  1  level; high once the power-up sequence is complete.
- `init_cmd`, `init_addr`  in  4/12  init block command and address.
- `ref_req`, `flag_ref_end`  in  1/1  refresh request level; refresh-done pulse.
- `aref_cmd`, `aref_addr`  in  4/12  refresh block command and address.
- `wr_req`, `flag_wr_end`  in  1/1  write request level; burst-done pulse.
- `wr_cmd`, `wr_addr`, `wr_bank`  in  4/12/2  write block pins.
- `rd_req`, `flag_rd_end`  in  1/1  read request level; burst-done pulse.
- `rd_cmd`, `rd_addr`, `rd_bank`  in  4/12/2  read block pins.
- `state`  out  5  FSM state, registered.
- `ref_en`, `wr_en`, `rd_en`  out  1 each  one-cycle grant pulses, registered.
- `sdram_cmd`, `sdram_addr`, `sdram_bank`  out  4/12/2  SDRAM command, address and bank (combinational mux).
- `sdram_cke`  out  1  clock enable, registered.
- `timeout_err`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- State encoding: IDLE=5'b00001, ARBIT=5'b00010, AREF=5'b00100, READ=5'b01000, WRITE=5'b10000. The READ encoding is fixed by the read block.
- IDLE -> ARBIT on the first edge with `flag_init_end`=1.
- ARBIT has fixed priority: `ref_req` > `wr_req` > `rd_req`.
  - On the transition edge the FSM moves to AREF, WRITE or READ and sets the matching `*_en` for exactly one cycle.
  - With no request, the FSM stays in ARBIT.
- AREF -> ARBIT on `flag_ref_end`, WRITE -> ARBIT on `flag_wr_end`, READ -> ARBIT on `flag_rd_end`.
- End flags that do not match the current state are ignored.
- Requests are not sampled outside ARBIT. A `ref_req` raised during READ/WRITE is served at the next ARBIT, so at most one burst is in flight.
- Watchdog:
  - An 8-bit `op_cnt` clears on entry to AREF/WRITE/READ and increments every cycle while the FSM is in one of those states.
  - When `op_cnt`==TIMEOUT and no end flag is present, the FSM goes to ARBIT and `timeout_err` pulses for one cycle.
  - If the end flag and expiry coincide, the end flag wins and there is no error.
  - `op_cnt` saturates and is held at 0 in IDLE/ARBIT.
- Pin mux:
  - IDLE: `init_cmd`/`init_addr`, bank 2'd0.
  - AREF: `aref_cmd`/`aref_addr`, bank 2'd0.
  - WRITE: `wr_*`.
  - READ: `rd_*`.
  - ARBIT or any illegal encoding: NOP, 12'd0, 2'd0.
- Illegal state register values recover to IDLE on the next edge.
- `sdram_cke`: 0 in reset, then 1 from the first edge after reset release.

## Timing
- Reset values:
  - `state`=IDLE.
  - `ref_en`=`wr_en`=`rd_en`=0, `timeout_err`=0, `sdram_cke`=0.
  - Pins follow `init_cmd`/`init_addr` with bank 0.
- Reset asserted mid-operation drops to IDLE immediately (asynchronous), clears all grants and the watchdog, and returns to ARBIT only via `flag_init_end`.
- Grant latency: a request seen in ARBIT at edge N gives `state` and `*_en` high in cycle N+1. `*_en` is low again from N+2.
- The requester drops its `*_req` at the edge where it sees `*_en`=1. The arbiter does not depend on that drop.
- End latency: `flag_*_end` high in cycle M gives `state`=ARBIT in cycle M+1. A pending request is granted at M+2, giving a minimum of one ARBIT cycle between operations.
- Pin mux has zero latency relative to `state`. Sub-block commands pass through combinationally.

## Test plan
- **Init:** reset, hold `flag_init_end`=0 for 20 cycles -> `state`=5'b00001, `sdram_cmd`=`init_cmd`, `sdram_cke`=1 after the first edge. Raise `flag_init_end` -> `state`=5'b00010 on the next cycle.
- **Priority:** in ARBIT, assert `ref_req`, `wr_req` and `rd_req` in the same cycle -> `state`=5'b00100 and `ref_en` pulses once. After `flag_ref_end`, WRITE is granted (`wr_en` pulse), then READ.
- **Read burst:** `rd_req`=1 and `flag_rd_end` pulsed 13 cycles after entry -> `state`=5'b01000 for exactly 14 cycles and `sdram_cmd` tracks `rd_cmd` throughout. `ref_req` raised mid-burst is not granted until ARBIT.
- **Stray flag:** pulse `flag_wr_end` during READ -> no transition, no error.
- **Watchdog:** enter READ and never pulse `flag_rd_end` -> return to ARBIT after `TIMEOUT`+1 cycles, `timeout_err`=1 for one cycle, pins NOP. Coincident end flag and expiry -> no error.
- **Reset mid-write:** assert `s_rst_n`=0 during WRITE -> `state`=IDLE, all `*_en` and `sdram_cke`=0 asynchronously.
